frame_commit_ctrl: RTL and testbench
====================================

Name: frame_commit_ctrl

Overview:
- Avalon-MM register front end that sequences sprite and background updates for the VGA sprite renderer.
- CPU writes land in shadow registers.
- A commit request arms the controller; shadow values are copied atomically to the active outputs at the start of vertical blank, so no frame shows a half-updated scene.
- Sits between the Avalon slave interface and the renderer; consumes hcount/vcount from the VGA counter block.

Parameters:
- VACTIVE, 480: first vblank line; commit strobe fires at vcount==VACTIVE && hcount==0.
- XMAX, 639: sprite x clamp limit.
- YMAX, 479: sprite y clamp limit.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  3  register index.
- writedata  in  16  write data.
- readdata  out  16  read data, 1-cycle latency.
- hcount  in  11  from VGA counters.
- vcount  in  10  from VGA counters.
- spr0_x, spr0_y, spr1_x, spr1_y  out  10 each  active sprite positions.
- bg_r, bg_g, bg_b  out  8 each  active background colour.
- committed  out  1  one-cycle pulse on commit.
- irq  out  1  level interrupt, commit done.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Register map (write):
  - 0 spr0_x, 1 spr0_y, 2 spr1_x, 3 spr1_y.
  - 4 bg RGB565.
  - 5 control: bit0 commit request, bit1 irq clear, bit2 irq enable.
  - 6, 7: writes ignored.
- Register map (read):
  - 0-4 return shadow values.
  - 6 status: bit0 armed, bit1 irq, bits15:8 commit count.
  - 5, 7 return 0.
- Clamping: x writes use min(writedata, XMAX) on the low bits; y writes use min(writedata, YMAX). Compare uses the full 16 bits, so 16'hFFFF clamps to XMAX.
- Background expansion: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
- vblank_start: combinational (vcount==VACTIVE && hcount==0), true for exactly one clk per frame.
- FSM states:
  - IDLE: ctrl bit0 write -> ARMED.
  - ARMED: on vblank_start, active<=shadow, committed=1 for that cycle, count++ (mod 256), irq<=irq|irq_en, next state IDLE.
  - ARMED plus repeat commit request: stays ARMED (idempotent).
- Simultaneous events:
  - Commit request while IDLE in the same cycle as vblank_start: go ARMED; commit on the next frame, not this one.
  - Shadow write in the same cycle as commit: active takes the pre-write shadow; shadow takes the new value; still armed=0.
  - Irq clear and irq set in the same cycle: set wins.
- Irq enable: irq_en=0 suppresses irq but not committed or count.
- Reset values:
  - shadow = active: spr0=(100,100), spr1=(200,100), bg=16'h0000.
  - bg outputs 0, readdata 0, committed 0, irq 0, irq_en 0, count 0, state IDLE.
- Reset mid-ARMED: pending commit discarded; active returns to reset values.
- Reads: readdata registered when chipselect&&read, otherwise holds its value.

Optional Feature:
- Macro: FRAME_COMMIT_AUTO_EN.
- With it defined:
  - A dirty flag sets on any shadow write to addresses 0-4.
  - In IDLE, vblank_start with dirty=1 commits exactly as ARMED does and clears dirty.
  - A write in the commit cycle re-sets dirty.
  - Status bit2 reads dirty.
- Without it: commit only via explicit request; status bit2 reads 0.

Decomposition:
- Package vga_ctrl_pkg:
  - Register address constants (ADDR_SPR0_X..ADDR_STATUS).
  - Control bit indices.
  - State enum (IDLE, ARMED).
  - Reset-position constants.
  - RGB565 field widths.
- Sub-module vblank_strobe: hcount/vcount compare producing the one-cycle vblank_start, reused by the renderer.

Test Plan:
1. Reset, write spr0_x=300, read addr0 -> 300; spr0_x output stays 100 until commit.
2. Write spr1_y=50, ctrl=0x5, run to vcount=480/hcount=0 -> spr1_y=50 that cycle, committed pulse 1 clk, irq=1, status[15:8]=1; write ctrl=0x2 -> irq=0.
3. Write spr0_x=16'hFFFF -> read 639; write bg=16'hF800 and commit -> bg_r=FF, bg_g=00, bg_b=00.
4. Commit request in the vblank_start cycle from IDLE -> no commit this frame; commit at the next frame's vblank_start.
5. Shadow write spr0_y=200 in the commit cycle, previous shadow 120 -> active 120, shadow 200, armed=0.
6. Assert reset while ARMED -> state IDLE, outputs at reset values, no committed pulse at the following vblank.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA frame-commit register front end and renderer:
// register map, control/status bit positions, FSM states, reset scene, RGB565 helpers.
package vga_ctrl_pkg;

    localparam logic [2:0] ADDR_SPR0_X = 3'd0;
    localparam logic [2:0] ADDR_SPR0_Y = 3'd1;
    localparam logic [2:0] ADDR_SPR1_X = 3'd2;
    localparam logic [2:0] ADDR_SPR1_Y = 3'd3;
    localparam logic [2:0] ADDR_BG     = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_IRQ_CLR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_ARMED = 0;
    localparam int STAT_IRQ   = 1;
    localparam int STAT_DIRTY = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [9:0]  RST_SPR0_X = 10'd100;
    localparam logic [9:0]  RST_SPR0_Y = 10'd100;
    localparam logic [9:0]  RST_SPR1_X = 10'd200;
    localparam logic [9:0]  RST_SPR1_Y = 10'd100;
    localparam logic [15:0] RST_BG     = 16'h0000;

    localparam int R5_W = 5;
    localparam int G6_W = 6;
    localparam int B5_W = 5;

    // Full 16-bit compare so out-of-range values such as 16'hFFFF saturate at the limit.
    function automatic logic [9:0] clamp10(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim[9:0] : v[9:0];
    endfunction

    function automatic logic [7:0] expand_r(input logic [15:0] c);
        logic [R5_W-1:0] r5;
        r5 = c[15:11];
        return {r5, r5[4:2]};
    endfunction

    function automatic logic [7:0] expand_g(input logic [15:0] c);
        logic [G6_W-1:0] g6;
        g6 = c[10:5];
        return {g6, g6[5:4]};
    endfunction

    function automatic logic [7:0] expand_b(input logic [15:0] c);
        logic [B5_W-1:0] b5;
        b5 = c[4:0];
        return {b5, b5[4:2]};
    endfunction

endpackage

// File: rtl/vblank_strobe.sv
// One-cycle vertical-blank start strobe decoded from the VGA counters.
// Purely combinational; true only at the first pixel of the first blank line.
module vblank_strobe #(
    parameter int VACTIVE = 480
) (
    input  logic [10:0] i_hcount,
    input  logic [9:0]  i_vcount,
    output logic        o_vblank_start
);

    assign o_vblank_start = (i_vcount == 10'(VACTIVE)) && (i_hcount == 11'd0);

endmodule

// File: rtl/frame_commit_ctrl.sv
// Avalon-MM shadow registers copied atomically to the renderer at vblank start; readdata has 1-cycle latency.
// Optional FRAME_COMMIT_AUTO_EN: commits dirty shadow state at vblank without an explicit request.
module frame_commit_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int VACTIVE = 480,
    parameter int XMAX    = 639,
    parameter int YMAX    = 479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [9:0]  spr0_x,
    output logic [9:0]  spr0_y,
    output logic [9:0]  spr1_x,
    output logic [9:0]  spr1_y,
    output logic [7:0]  bg_r,
    output logic [7:0]  bg_g,
    output logic [7:0]  bg_b,
    output logic        committed,
    output logic        irq
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_commit;
    logic        w_vblank_start;

    logic [9:0]  r_sh_spr0_x, r_sh_spr0_y, r_sh_spr1_x, r_sh_spr1_y;
    logic [15:0] r_sh_bg;
    logic [9:0]  r_act_spr0_x, r_act_spr0_y, r_act_spr1_x, r_act_spr1_y;
    logic [15:0] r_act_bg;
    logic [7:0]  r_count;
    logic        r_irq;
    logic        r_irq_en;
    logic [15:0] r_readdata;
    logic [15:0] w_rd_mux;
    logic        w_dirty;

    logic w_wr, w_rd, w_ctrl_wr, w_commit_req, w_shadow_wr;

    assign w_wr         = chipselect && write;
    assign w_rd         = chipselect && read;
    assign w_ctrl_wr    = w_wr && (address == ADDR_CTRL);
    assign w_commit_req = w_ctrl_wr && writedata[CTRL_COMMIT];
    assign w_shadow_wr  = w_wr && (address <= ADDR_BG);

    vblank_strobe #(
        .VACTIVE (VACTIVE)
    ) u_vblank_strobe (
        .i_hcount       (hcount),
        .i_vcount       (vcount),
        .o_vblank_start (w_vblank_start)
    );

`ifdef FRAME_COMMIT_AUTO_EN
    logic r_dirty;

    // A write landing in the commit cycle belongs to the next frame, so it wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty <= 1'b0;
        end else if (w_shadow_wr) begin
            r_dirty <= 1'b1;
        end else if (w_commit) begin
            r_dirty <= 1'b0;
        end
    end

    assign w_dirty = r_dirty;
`else
    assign w_dirty = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request arriving in the vblank cycle while idle only arms; the commit waits a full frame.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef FRAME_COMMIT_AUTO_EN
                if (w_vblank_start && w_dirty) begin
                    w_commit = 1'b1;
                end
`endif
                if (w_commit_req) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_vblank_start) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_spr0_x <= RST_SPR0_X;
            r_sh_spr0_y <= RST_SPR0_Y;
            r_sh_spr1_x <= RST_SPR1_X;
            r_sh_spr1_y <= RST_SPR1_Y;
            r_sh_bg     <= RST_BG;
        end else if (w_wr) begin
            case (address)
                ADDR_SPR0_X: r_sh_spr0_x <= clamp10(writedata, 16'(XMAX));
                ADDR_SPR0_Y: r_sh_spr0_y <= clamp10(writedata, 16'(YMAX));
                ADDR_SPR1_X: r_sh_spr1_x <= clamp10(writedata, 16'(XMAX));
                ADDR_SPR1_Y: r_sh_spr1_y <= clamp10(writedata, 16'(YMAX));
                ADDR_BG:     r_sh_bg     <= writedata;
                default: ;
            endcase
        end
    end

    // Non-blocking copy means a same-cycle shadow write is not seen by the active set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_spr0_x <= RST_SPR0_X;
            r_act_spr0_y <= RST_SPR0_Y;
            r_act_spr1_x <= RST_SPR1_X;
            r_act_spr1_y <= RST_SPR1_Y;
            r_act_bg     <= RST_BG;
            r_count      <= 8'd0;
        end else if (w_commit) begin
            r_act_spr0_x <= r_sh_spr0_x;
            r_act_spr0_y <= r_sh_spr0_y;
            r_act_spr1_x <= r_sh_spr1_x;
            r_act_spr1_y <= r_sh_spr1_y;
            r_act_bg     <= r_sh_bg;
            r_count      <= r_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_commit && r_irq_en) begin
                r_irq <= 1'b1;
            end else if (w_ctrl_wr && writedata[CTRL_IRQ_CLR]) begin
                r_irq <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= writedata[CTRL_IRQ_EN];
            end
        end
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (address)
            ADDR_SPR0_X: w_rd_mux = {6'd0, r_sh_spr0_x};
            ADDR_SPR0_Y: w_rd_mux = {6'd0, r_sh_spr0_y};
            ADDR_SPR1_X: w_rd_mux = {6'd0, r_sh_spr1_x};
            ADDR_SPR1_Y: w_rd_mux = {6'd0, r_sh_spr1_y};
            ADDR_BG:     w_rd_mux = r_sh_bg;
            ADDR_STATUS: begin
                w_rd_mux[15:8]       = r_count;
                w_rd_mux[STAT_ARMED] = (r_state == ST_ARMED);
                w_rd_mux[STAT_IRQ]   = r_irq;
                w_rd_mux[STAT_DIRTY] = w_dirty;
            end
            default: w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 16'h0000;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata  = r_readdata;
    assign spr0_x    = r_act_spr0_x;
    assign spr0_y    = r_act_spr0_y;
    assign spr1_x    = r_act_spr1_x;
    assign spr1_y    = r_act_spr1_y;
    assign bg_r      = expand_r(r_act_bg);
    assign bg_g      = expand_g(r_act_bg);
    assign bg_b      = expand_b(r_act_bg);
    assign committed = w_commit;
    assign irq       = r_irq;

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Bench for frame_commit_ctrl: directed scenarios plus random register traffic against a register-map model.
// The VGA counters are shortened (16 pixels, lines 470..489) so frames arrive quickly.
module tb_frame_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  spr0_x, spr0_y, spr1_x, spr1_y;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        committed, irq;

    always #5 clk = ~clk;

    frame_commit_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .hcount     (hcount),
        .vcount     (vcount),
        .spr0_x     (spr0_x),
        .spr0_y     (spr0_y),
        .spr1_x     (spr1_x),
        .spr1_y     (spr1_y),
        .bg_r       (bg_r),
        .bg_g       (bg_g),
        .bg_b       (bg_b),
        .committed  (committed),
        .irq        (irq)
    );

    localparam int HW = 16;
    localparam int V0 = 470;
    localparam int V1 = 489;

    int checks = 0;
    int errors = 0;

    // Model: indices 0..4 follow the register map (spr0_x, spr0_y, spr1_x, spr1_y, bg).
    int m_sh[5];
    int m_act[5];
    bit m_armed, m_irq, m_irq_en;
    int m_count;
    int m_rd;

    int fh = 0;
    int fv = V0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh[0] = 100; m_sh[1] = 100; m_sh[2] = 200; m_sh[3] = 100; m_sh[4] = 0;
        for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
        m_armed = 0; m_irq = 0; m_irq_en = 0; m_count = 0; m_rd = 0;
    endtask

    function automatic int read_model(input int a);
        if (a <= 4) return m_sh[a];
        if (a == 6) return m_count * 256 + (m_irq ? 2 : 0) + (m_armed ? 1 : 0);
        return 0;
    endfunction

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    task automatic compare_outputs();
        int r5, g6, b5;
        r5 = m_act[4] / 2048;
        g6 = (m_act[4] / 32) % 64;
        b5 = m_act[4] % 32;
        check("readdata", 32'(readdata), 32'(m_rd));
        check("spr0_x", 32'(spr0_x), 32'(m_act[0]));
        check("spr0_y", 32'(spr0_y), 32'(m_act[1]));
        check("spr1_x", 32'(spr1_x), 32'(m_act[2]));
        check("spr1_y", 32'(spr1_y), 32'(m_act[3]));
        check("bg_r", 32'(bg_r), 32'(r5 * 8 + r5 / 4));
        check("bg_g", 32'(bg_g), 32'(g6 * 4 + g6 / 16));
        check("bg_b", 32'(bg_b), 32'(b5 * 8 + b5 / 4));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    // One clock: drive inputs, check the combinational pulse mid-cycle, update model at the edge, check after.
    task automatic step(input bit cs, input bit wr, input bit rd, input int a, input int d);
        bit vb, cmt, ctrl;
        chipselect = cs; write = wr; read = rd;
        address = 3'(a); writedata = 16'(d);
        hcount = 11'(fh); vcount = 10'(fv);
        vb  = (fv == 480) && (fh == 0);
        cmt = m_armed && vb;
        @(negedge clk);
        check("committed", 32'(committed), 32'(cmt));
        @(posedge clk);
        ctrl = cs && wr && (a == 5);
        if (cs && rd) m_rd = read_model(a);
        if (cmt) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_count = (m_count + 1) % 256;
        end
        if (ctrl && d[1]) m_irq = 0;
        if (cmt && m_irq_en) m_irq = 1;
        if (ctrl) m_irq_en = d[2];
        if (cmt) m_armed = 0;
        else if (ctrl && d[0]) m_armed = 1;
        if (cs && wr) begin
            case (a)
                0, 2: m_sh[a] = lim(d, 639);
                1, 3: m_sh[a] = lim(d, 479);
                4:    m_sh[a] = d;
                default: ;
            endcase
        end
        #1;
        compare_outputs();
        fh++;
        if (fh == HW) begin
            fh = 0;
            fv++;
            if (fv > V1) fv = V0;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic wreg(input int a, input int d);
        step(1, 1, 0, a, d);
    endtask

    task automatic rreg(input int a);
        step(1, 0, 1, a, 0);
    endtask

    // Leaves the counters so that the next step is the vblank_start cycle.
    task automatic run_to_vb();
        for (int i = 0; i < 400 && !(fh == 0 && fv == 480); i++) idle();
        if (!(fh == 0 && fv == 480)) begin
            errors++;
            checks++;
            $display("FAIL run_to_vb bound expired fh=%0d fv=%0d required 0/480", fh, fv);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #2;
        model_reset();
        check("rst_spr0_x", 32'(spr0_x), 32'd100);
        check("rst_readdata", 32'(readdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
        hcount = 0; vcount = 10'(V0);
        model_reset();
        #2;
        check("reset_spr0_x", 32'(spr0_x), 32'd100);
        check("reset_spr0_y", 32'(spr0_y), 32'd100);
        check("reset_spr1_x", 32'(spr1_x), 32'd200);
        check("reset_spr1_y", 32'(spr1_y), 32'd100);
        check("reset_bg_r", 32'(bg_r), 32'd0);
        check("reset_readdata", 32'(readdata), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_committed", 32'(committed), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Shadow write is readable but not visible until commit
        wreg(0, 300);
        rreg(0);
        check("t1_read0", 32'(readdata), 32'd300);
        check("t1_spr0_x_held", 32'(spr0_x), 32'd100);

        // Commit with irq enabled, then clear
        wreg(3, 50);
        wreg(5, 5);
        run_to_vb();
        idle();
        check("t2_spr1_y", 32'(spr1_y), 32'd50);
        check("t2_irq", 32'(irq), 32'd1);
        rreg(6);
        check("t2_count", 32'(readdata[15:8]), 32'd1);
        check("t2_armed", 32'(readdata[0]), 32'd0);
        wreg(5, 2);
        check("t2_irq_clr", 32'(irq), 32'd0);

        // Clamp and RGB565 expansion
        wreg(0, 16'hFFFF);
        rreg(0);
        check("t3_clamp", 32'(readdata), 32'd639);
        wreg(1, 1000);
        rreg(1);
        check("t3_clamp_y", 32'(readdata), 32'd479);
        wreg(4, 16'hF800);
        wreg(5, 1);
        run_to_vb();
        idle();
        check("t3_bg_r", 32'(bg_r), 32'hFF);
        check("t3_bg_g", 32'(bg_g), 32'h00);
        check("t3_bg_b", 32'(bg_b), 32'h00);

        // Request in the vblank cycle from idle waits for the next frame
        wreg(2, 333);
        run_to_vb();
        wreg(5, 1);
        rreg(6);
        check("t4_armed", 32'(readdata[0]), 32'd1);
        check("t4_spr1_x_held", 32'(spr1_x), 32'd200);
        run_to_vb();
        idle();
        check("t4_spr1_x", 32'(spr1_x), 32'd333);

        // Shadow write in the commit cycle
        wreg(1, 120);
        wreg(5, 1);
        run_to_vb();
        wreg(1, 200);
        check("t5_active", 32'(spr0_y), 32'd120);
        rreg(1);
        check("t5_shadow", 32'(readdata), 32'd200);
        rreg(6);
        check("t5_armed", 32'(readdata[0]), 32'd0);

        // Irq clear collides with irq set: set wins
        wreg(5, 5);
        run_to_vb();
        wreg(5, 6);
        check("t7_set_wins", 32'(irq), 32'd1);
        wreg(5, 2);

        // Reset while armed discards the pending commit
        wreg(0, 5);
        wreg(5, 1);
        do_reset();
        run_to_vb();
        idle();
        check("t6_spr0_x", 32'(spr0_x), 32'd100);
        rreg(6);
        check("t6_count", 32'(readdata[15:8]), 32'd0);

        // Random register traffic
        for (int n = 0; n < 4000; n++) begin
            int r, a, d;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            if (a == 5) d = $urandom_range(0, 7);
            else if ($urandom_range(0, 3) == 0) d = int'(16'($urandom));
            else d = $urandom_range(0, 700);
            if (a == 5 && m_armed && fh == 0 && fv == 480) d = d & 6;
            if (r < 4) idle();
            else if (r < 7) wreg(a, d);
            else rreg(a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
